// File: rtl/cpu_bus_arbiter_if.sv
// Signal bundle for cpu_bus_arbiter: per-master request/response lanes plus the single slave
// channel. The arbiter binds modport master (it masters the slave bus); the environment binds slave.
interface cpu_bus_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32
);

  logic [NUM_MASTERS-1:0]            m_req;
  logic [NUM_MASTERS-1:0]            m_we;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata;
  logic [DATA_WIDTH-1:0]             m_rdata;
  logic [NUM_MASTERS-1:0]            m_ack;
  logic [NUM_MASTERS-1:0]            m_err;

  logic                              s_valid;
  logic                              s_we;
  logic [ADDR_WIDTH-1:0]             s_addr;
  logic [DATA_WIDTH-1:0]             s_wdata;
  logic [DATA_WIDTH-1:0]             s_rdata;
  logic                              s_ready;

  modport master (
    input  m_req,
    input  m_we,
    input  m_addr,
    input  m_wdata,
    output m_rdata,
    output m_ack,
    output m_err,
    output s_valid,
    output s_we,
    output s_addr,
    output s_wdata,
    input  s_rdata,
    input  s_ready
  );

  modport slave (
    output m_req,
    output m_we,
    output m_addr,
    output m_wdata,
    input  m_rdata,
    input  m_ack,
    input  m_err,
    input  s_valid,
    input  s_we,
    input  s_addr,
    input  s_wdata,
    output s_rdata,
    output s_ready
  );

endinterface

// File: rtl/cpu_bus_arbiter.sv
// Round-robin arbiter letting NUM_MASTERS masters share one valid/ready slave bus, one transaction
// in flight. Defining ARB_TIMEOUT_EN adds a slave-wait limit that completes the access with m_err.
module cpu_bus_arbiter #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  cpu_bus_arbiter_if.master bus_io
);

  localparam int unsigned    IdxW    = $clog2(NUM_MASTERS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_MASTERS - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  if (NUM_MASTERS < 2) begin : g_bad_masters
    $error("cpu_bus_arbiter: NUM_MASTERS must be at least 2");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("cpu_bus_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]             state_q, state_d;
  // Also names the owner of the transaction in flight while BUSY/RESP.
  logic [IdxW-1:0]        last_grant_q, last_grant_d;
  logic                   s_valid_q, s_valid_d;
  logic                   s_we_q, s_we_d;
  logic [ADDR_WIDTH-1:0]  s_addr_q, s_addr_d;
  logic [DATA_WIDTH-1:0]  s_wdata_q, s_wdata_d;
  logic [DATA_WIDTH-1:0]  m_rdata_q, m_rdata_d;
  logic [NUM_MASTERS-1:0] m_ack_q, m_ack_d;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [NUM_MASTERS-1:0] m_err_q, m_err_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
`endif

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_MASTERS];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_MASTERS];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign addr_arr[i]  = bus_io.m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[i] = bus_io.m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search starts one past the last grant so the previous winner has lowest priority.
  logic            req_found;
  logic [IdxW-1:0] req_idx;
  logic [IdxW-1:0] cand_idx;
  int unsigned     cand;

  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      cand     = (32'(last_grant_q) + k) % NUM_MASTERS;
      cand_idx = IdxW'(cand);
      if (!req_found && bus_io.m_req[cand_idx]) begin
        req_found = 1'b1;
        req_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    s_valid_d    = s_valid_q;
    s_we_d       = s_we_q;
    s_addr_d     = s_addr_q;
    s_wdata_d    = s_wdata_q;
    m_rdata_d    = m_rdata_q;
    m_ack_d      = '0;
`ifdef ARB_TIMEOUT_EN
    m_err_d      = '0;
    cnt_d        = cnt_q;
`endif

    case (state_q)
      StIdle: begin
        if (req_found) begin
          last_grant_d = req_idx;
          s_valid_d    = 1'b1;
          s_we_d       = bus_io.m_we[req_idx];
          s_addr_d     = addr_arr[req_idx];
          s_wdata_d    = wdata_arr[req_idx];
          state_d      = StBusy;
`ifdef ARB_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end
      end

      StBusy: begin
        if (bus_io.s_ready) begin
          s_valid_d             = 1'b0;
          m_rdata_d             = bus_io.s_rdata;
          m_ack_d[last_grant_q] = 1'b1;
          state_d               = StResp;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT_CYCLES)) begin
          s_valid_d             = 1'b0;
          m_rdata_d             = '0;
          m_ack_d[last_grant_q] = 1'b1;
          m_err_d[last_grant_q] = 1'b1;
          state_d               = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end

      // Ack/err are asserted for this single cycle; requests are not looked at here.
      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d   = StIdle;
        s_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= LastIdx;
      s_valid_q    <= 1'b0;
      s_we_q       <= 1'b0;
      s_addr_q     <= '0;
      s_wdata_q    <= '0;
      m_rdata_q    <= '0;
      m_ack_q      <= '0;
`ifdef ARB_TIMEOUT_EN
      m_err_q      <= '0;
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      s_valid_q    <= s_valid_d;
      s_we_q       <= s_we_d;
      s_addr_q     <= s_addr_d;
      s_wdata_q    <= s_wdata_d;
      m_rdata_q    <= m_rdata_d;
      m_ack_q      <= m_ack_d;
`ifdef ARB_TIMEOUT_EN
      m_err_q      <= m_err_d;
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign bus_io.s_valid = s_valid_q;
  assign bus_io.s_we    = s_we_q;
  assign bus_io.s_addr  = s_addr_q;
  assign bus_io.s_wdata = s_wdata_q;
  assign bus_io.m_rdata = m_rdata_q;
  assign bus_io.m_ack   = m_ack_q;
`ifdef ARB_TIMEOUT_EN
  assign bus_io.m_err   = m_err_q;
`else
  assign bus_io.m_err   = '0;
`endif

`ifndef SYNTHESIS
  a_ack_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(m_ack_q));

  a_slave_hold : assert property (@(posedge clk) disable iff (reset)
    s_valid_q && !bus_io.s_ready |=> $stable({s_we_q, s_addr_q, s_wdata_q}));

`ifdef ARB_TIMEOUT_EN
  a_err_with_ack : assert property (@(posedge clk) disable iff (reset)
    (m_err_q & ~m_ack_q) == '0);
`endif
`endif

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Randomised and directed bench for cpu_bus_arbiter, checked every cycle against a
// transaction-level round-robin model; honours ARB_TIMEOUT_EN like the design.
module tb_cpu_bus_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
`else
  localparam bit TimeoutOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  cpu_bus_arbiter_if #(.NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  cpu_bus_arbiter #(
    .NUM_MASTERS   (N),
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, how long the slave has stalled, and the outputs
  // the rules demand after each clock edge.
  bit              mdl_live = 1'b0;
  bit              mdl_busy;
  bit              mdl_resp;
  int              mdl_ptr;
  int              mdl_owner;
  int              mdl_wait;
  logic            exp_valid;
  logic            exp_we;
  logic [AW-1:0]   exp_addr;
  logic [DW-1:0]   exp_wdata;
  logic [DW-1:0]   exp_rdata;
  logic [N-1:0]    exp_ack;
  logic [N-1:0]    exp_err;

  task automatic model_step();
    int best;
    int best_rank;
    int rank;
    if (reset) begin
      mdl_live  = 1'b1;
      mdl_busy  = 1'b0;
      mdl_resp  = 1'b0;
      mdl_ptr   = N - 1;
      mdl_owner = 0;
      mdl_wait  = 0;
      exp_valid = 1'b0;
      exp_we    = 1'b0;
      exp_addr  = '0;
      exp_wdata = '0;
      exp_rdata = '0;
      exp_ack   = '0;
      exp_err   = '0;
      return;
    end
    exp_ack = '0;
    exp_err = '0;
    if (mdl_resp) begin
      mdl_resp = 1'b0;
    end else if (mdl_busy) begin
      if (bus.s_ready) begin
        exp_valid          = 1'b0;
        exp_rdata          = bus.s_rdata;
        exp_ack[mdl_owner] = 1'b1;
        mdl_busy           = 1'b0;
        mdl_resp           = 1'b1;
      end else if (TimeoutOn && mdl_wait == TO) begin
        exp_valid          = 1'b0;
        exp_rdata          = '0;
        exp_ack[mdl_owner] = 1'b1;
        exp_err[mdl_owner] = 1'b1;
        mdl_busy           = 1'b0;
        mdl_resp           = 1'b1;
      end else begin
        mdl_wait++;
      end
    end else begin
      // Rank 0 is the master just after the previous winner.
      best      = -1;
      best_rank = N;
      for (int i = 0; i < N; i++) begin
        if (bus.m_req[i]) begin
          rank = (i - mdl_ptr - 1 + 2 * N) % N;
          if (rank < best_rank) begin
            best_rank = rank;
            best      = i;
          end
        end
      end
      if (best >= 0) begin
        mdl_owner = best;
        mdl_ptr   = best;
        mdl_wait  = 0;
        mdl_busy  = 1'b1;
        exp_valid = 1'b1;
        exp_we    = bus.m_we[best];
        exp_addr  = bus.m_addr[best*AW +: AW];
        exp_wdata = bus.m_wdata[best*DW +: DW];
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (mdl_live) begin
      check("s_valid", bus.s_valid, exp_valid);
      check("s_we", bus.s_we, exp_we);
      check("s_addr", bus.s_addr, exp_addr);
      check("s_wdata", bus.s_wdata, exp_wdata);
      check("m_rdata", bus.m_rdata, exp_rdata);
      check("m_ack", bus.m_ack, exp_ack);
      check("m_err", bus.m_err, exp_err);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int i, input logic req, input logic we,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.m_req[i]           = req;
    bus.m_we[i]            = we;
    bus.m_addr[i*AW +: AW]  = a;
    bus.m_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    int grants[$];
    int exp_rr[4];
    int found;
    int acks;
    int thresh;
    logic prev_valid;

    reset         = 1'b1;
    bus.m_req     = '0;
    bus.m_we      = '0;
    bus.m_addr    = '0;
    bus.m_wdata   = '0;
    bus.s_ready   = 1'b0;
    bus.s_rdata   = '0;

    // Reset with both masters requesting: everything stays at zero.
    set_master(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
    set_master(1, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
    repeat (3) next_cycle();
    check("rst_s_valid", bus.s_valid, 0);
    check("rst_s_addr", bus.s_addr, 0);
    check("rst_m_ack", bus.m_ack, 0);
    check("rst_m_err", bus.m_err, 0);
    check("rst_m_rdata", bus.m_rdata, 0);
    reset       = 1'b0;
    bus.s_ready = 1'b1;
    bus.s_rdata = 32'h1111_1111;
    next_cycle();
    check("first_grant_valid", bus.s_valid, 1);
    check("first_grant_addr", bus.s_addr, 32'h0000_0100);
    bus.m_req = '0;
    next_cycle();
    check("first_grant_ack", bus.m_ack, 2'b01);
    next_cycle();

    // Single read by master 1 with a zero-wait slave.
    set_master(1, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
    bus.s_rdata = 32'hCAFE_BABE;
    next_cycle();
    check("rd_s_valid_c1", bus.s_valid, 1);
    check("rd_s_we_c1", bus.s_we, 0);
    check("rd_s_addr_c1", bus.s_addr, 32'h0000_0040);
    check("rd_ack_c1", bus.m_ack, 0);
    bus.m_req = '0;
    next_cycle();
    check("rd_ack_c2", bus.m_ack, 2'b10);
    check("rd_rdata_c2", bus.m_rdata, 32'hCAFE_BABE);
    next_cycle();

    // Round-robin with both masters requesting continuously.
    exp_rr = '{0, 1, 0, 1};
    set_master(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
    set_master(1, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
    prev_valid = 1'b0;
    for (int k = 0; k < 20 && grants.size() < 4; k++) begin
      next_cycle();
      if (bus.s_valid && !prev_valid) grants.push_back((bus.s_addr == 32'h0000_0200) ? 1 : 0);
      prev_valid = bus.s_valid;
    end
    bus.m_req = '0;
    check("rr_grant_count", grants.size(), 4);
    for (int k = 0; k < grants.size() && k < 4; k++) begin
      check($sformatf("rr_grant_%0d", k), grants[k], exp_rr[k]);
    end
    repeat (3) next_cycle();

    // Write by master 0 with three slave wait states; master scrambles its inputs meanwhile.
    set_master(0, 1'b1, 1'b1, 32'h0000_0300, 32'h1234_5678);
    bus.s_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      check($sformatf("ws_valid_%0d", k), bus.s_valid, 1);
      check($sformatf("ws_we_%0d", k), bus.s_we, 1);
      check($sformatf("ws_addr_%0d", k), bus.s_addr, 32'h0000_0300);
      check($sformatf("ws_wdata_%0d", k), bus.s_wdata, 32'h1234_5678);
      check($sformatf("ws_ack_%0d", k), bus.m_ack, 0);
      set_master(0, 1'b1, 1'b0, 32'hDEAD_0000 + 32'(k), 32'h0);
      if (k == 3) bus.s_ready = 1'b1;
    end
    next_cycle();
    check("ws_ack", bus.m_ack, 2'b01);
    bus.m_req   = '0;
    bus.s_ready = 1'b0;
    next_cycle();
    check("ws_ack_single", bus.m_ack, 0);
    next_cycle();

    // Reset while BUSY on master 0: pointer returns so master 0 also wins the next contention.
    set_master(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
    next_cycle();
    check("rb_valid_busy", bus.s_valid, 1);
    reset = 1'b1;
    set_master(1, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
    next_cycle();
    check("rb_valid_after_reset", bus.s_valid, 0);
    check("rb_no_ack", bus.m_ack, 0);
    reset = 1'b0;
    next_cycle();
    check("rb_regrant_valid", bus.s_valid, 1);
    check("rb_regrant_addr", bus.s_addr, 32'h0000_0100);
    check("rb_no_ack2", bus.m_ack, 0);
    bus.m_req   = '0;
    bus.s_ready = 1'b1;
    bus.s_rdata = 32'hA5A5_A5A5;
    next_cycle();
    check("rb_ack", bus.m_ack, 2'b01);
    bus.s_ready = 1'b0;
    next_cycle();

    // Slave that never answers.
    set_master(1, 1'b1, 1'b0, 32'h0000_0500, 32'h0);
    bus.s_rdata = 32'hFFFF_FFFF;
`ifdef ARB_TIMEOUT_EN
    found = 0;
    for (int k = 1; k <= 40 && found == 0; k++) begin
      next_cycle();
      if (bus.m_ack != '0) found = k;
    end
    check("to_latency", found, 10);
    check("to_ack", bus.m_ack, 2'b10);
    check("to_err", bus.m_err, 2'b10);
    check("to_rdata", bus.m_rdata, 0);
    bus.m_req = '0;
    next_cycle();
    check("to_err_single", bus.m_err, 0);
`else
    acks = 0;
    for (int k = 0; k < 100; k++) begin
      next_cycle();
      if (bus.m_ack != '0 || bus.m_err != '0) acks++;
    end
    check("no_to_acks", acks, 0);
    check("no_to_still_valid", bus.s_valid, 1);
    bus.m_req = '0;
    reset     = 1'b1;
    next_cycle();
    reset = 1'b0;
`endif
    next_cycle();

    // Random traffic: masters follow the hold-until-ack contract, slave stalls at random.
    for (int c = 0; c < 3000; c++) begin
      thresh = (c < 1500) ? 5 : 1;
      next_cycle();
      reset = ($urandom_range(0, 249) == 0);
      for (int i = 0; i < N; i++) begin
        if (bus.m_ack[i]) begin
          if ($urandom_range(0, 1) == 0) bus.m_req[i] = 1'b0;
          else set_master(i, 1'b1, 1'($urandom), $urandom, $urandom);
        end else if (!bus.m_req[i]) begin
          if ($urandom_range(0, 2) == 0) set_master(i, 1'b1, 1'($urandom), $urandom, $urandom);
        end else if ($urandom_range(0, 19) == 0) begin
          bus.m_req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          set_master(i, 1'b1, 1'($urandom), $urandom, $urandom);
        end
      end
      bus.s_ready = (int'($urandom_range(0, 7)) < thresh);
      bus.s_rdata = $urandom;
    end

    reset     = 1'b0;
    bus.m_req = '0;
    repeat (40) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
